// File: rtl/instr_link_pkg.sv
// rtl/instr_link_pkg.sv - shared types and defaults for the servo instruction link
package instr_link_pkg;

    localparam int INSTR_WIDTH               = 10;
    localparam int LINK_RESET_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        LINK_RST,
        WAIT_RDY,
        SETUP,
        CONFIRM,
        HOLD,
        DONE
    } tx_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous input
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/instruction_tx.sv
// rtl/instruction_tx.sv - serial instruction transmitter, MSB first over data_bit/confirm_bit
module instruction_tx
    import instr_link_pkg::*;
#(
    parameter int WIDTH             = INSTR_WIDTH,
    parameter int SETUP_CYCLES      = 2,
    parameter int HOLD_CYCLES       = 16,
    parameter int LINK_RESET_CYCLES = LINK_RESET_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] instr,
    input  logic             waiting_bit,
    output logic             data_bit,
    output logic             confirm_bit,
    output logic             link_reset,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int BC_W   = $clog2(WIDTH + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PH_MAX = (HOLD_CYCLES > SETUP_CYCLES)
                          ? ((HOLD_CYCLES > LINK_RESET_CYCLES) ? HOLD_CYCLES : LINK_RESET_CYCLES)
                          : ((SETUP_CYCLES > LINK_RESET_CYCLES) ? SETUP_CYCLES : LINK_RESET_CYCLES);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    tx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [BC_W-1:0]  bit_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [PH_W-1:0]  ph_cnt;
    logic             abort_flag;
    logic             waiting_s;
    logic             timeout_hit;
    logic             abortable;

    sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (waiting_bit),
        .q     (waiting_s)
    );

    // Only the two handshake-wait states run the timeout counter.
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) &&
                         (((state == WAIT_RDY) && !waiting_s) ||
                          ((state == CONFIRM)  &&  waiting_s));
    assign abortable   = abort && (state != IDLE) && (state != LINK_RST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            ph_cnt      <= '0;
            abort_flag  <= 1'b0;
            data_bit    <= 1'b0;
            confirm_bit <= 1'b0;
            link_reset  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else if (timeout_hit) begin
            error       <= 1'b1;
            abort_flag  <= 1'b1;
            confirm_bit <= 1'b0;
            link_reset  <= 1'b1;
            ph_cnt      <= '0;
            state       <= LINK_RST;
        end else if (abortable) begin
            abort_flag  <= 1'b1;
            confirm_bit <= 1'b0;
            link_reset  <= 1'b1;
            done        <= 1'b0;
            ph_cnt      <= '0;
            state       <= LINK_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg      <= instr;
                        bit_cnt    <= '0;
                        error      <= 1'b0;
                        abort_flag <= 1'b0;
                        link_reset <= 1'b1;
                        busy       <= 1'b1;
                        ph_cnt     <= '0;
                        state      <= LINK_RST;
                    end
                end
                LINK_RST: begin
                    if (ph_cnt == PH_W'(LINK_RESET_CYCLES - 1)) begin
                        link_reset <= 1'b0;
                        ph_cnt     <= '0;
                        if (abort_flag) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            data_bit <= shreg[WIDTH-1];
                            to_cnt   <= '0;
                            state    <= WAIT_RDY;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (waiting_s) begin
                        ph_cnt <= '0;
                        state  <= SETUP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                SETUP: begin
                    if (ph_cnt == PH_W'(SETUP_CYCLES - 1)) begin
                        confirm_bit <= 1'b1;
                        to_cnt      <= '0;
                        state       <= CONFIRM;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                CONFIRM: begin
                    if (!waiting_s) begin
                        ph_cnt <= '0;
                        state  <= HOLD;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (ph_cnt == PH_W'(HOLD_CYCLES - 1)) begin
                        confirm_bit <= 1'b0;
                        shreg       <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt     <= bit_cnt + 1'b1;
                        if (bit_cnt == BC_W'(WIDTH - 1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Next bit is presented as the shift happens, so data_bit moves only here.
                            data_bit <= shreg[WIDTH-2];
                            to_cnt   <= '0;
                            state    <= WAIT_RDY;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instruction_tx.md
# instruction_tx

Serial instruction transmitter: the sending end of the 10-bit servo instruction link. Accepts a parallel instruction word from the host control logic and shifts it out MSB first over the data_bit/confirm_bit handshake, pacing each bit on the receiver's waiting_bit. Drives link_reset to re-arm the receiver before every frame and on abort or timeout.

## Interface
- WIDTH, 10, instruction length in bits.
- SETUP_CYCLES, 2, cycles data_bit is stable before confirm_bit rises.
- HOLD_CYCLES, 16, cycles confirm_bit stays high after waiting_bit falls (receiver needs >11).
- LINK_RESET_CYCLES, 4, link_reset pulse length (receiver needs ≥2).
- TIMEOUT_CYCLES, 4096, max cycles waiting on any waiting_bit edge.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request to send instr; honoured only in IDLE.
- abort  in  1  cancel frame in progress; ignored in IDLE.
- instr  in  WIDTH  word to send, captured on start acceptance.
- waiting_bit  in  1  receiver ready-for-bit, asynchronous to clk.
- data_bit  out  1  current serial bit.
- confirm_bit  out  1  bit-valid strobe.
- link_reset  out  1  drives receiver reset.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, frame delivered.
- error  out  1  sticky timeout flag; cleared on next accepted start or reset.

## Operation
- waiting_bit passes through a 2-flop synchronizer (waiting_s); all decisions use waiting_s.
- States: IDLE, LINK_RST, WAIT_RDY, SETUP, CONFIRM, HOLD, DONE.
- IDLE: start=1 → capture instr into shift register, bit_cnt=0, clear error, clear abort_flag → LINK_RST.
- LINK_RST: link_reset=1, confirm_bit=0 for LINK_RESET_CYCLES; then abort_flag ? IDLE : WAIT_RDY.
- WAIT_RDY: data_bit = shreg[WIDTH-1]; waiting_s=1 → SETUP.
- SETUP: confirm_bit=0 for SETUP_CYCLES → CONFIRM.
- CONFIRM: confirm_bit=1; waiting_s=0 → HOLD.
- HOLD: confirm_bit=1 for HOLD_CYCLES; then confirm_bit=0, shift left, bit_cnt+1; bit_cnt was WIDTH-1 → DONE else WAIT_RDY.
- DONE: done=1 one cycle → IDLE. Receiver remains in its complete state until the next frame's LINK_RST.
- Timeout: counter cleared on entry to WAIT_RDY and CONFIRM; reaching TIMEOUT_CYCLES in either → error=1, abort_flag=1 → LINK_RST.
- abort=1 in any state except IDLE/LINK_RST → abort_flag=1, confirm_bit=0 → LINK_RST; no done, error unchanged.
- data_bit changes only on entry to WAIT_RDY; stable through SETUP/CONFIRM/HOLD.
- bit_cnt width $clog2(WIDTH+1); timeout counter width $clog2(TIMEOUT_CYCLES+1); no wrap.

## Timing
- Reset values: data_bit 0, confirm_bit 0, link_reset 0, busy 0, done 0, error 0; state IDLE. Reset mid-frame aborts silently; receiver is re-armed by the next frame's LINK_RST.
- Start accepted at edge N: busy and link_reset high from N+1.
- Per-bit minimum: 2 (sync) + SETUP_CYCLES + 1 + 2 (sync) + HOLD_CYCLES cycles.
- start while busy: ignored, instr not recaptured. start and abort together in IDLE: start wins.
- abort and timeout same cycle: treated as timeout (error set).
- done and busy: done asserted in DONE with busy=1; busy=0 the cycle after.

## Structure
- Package instr_link_pkg: state enum, default WIDTH constant, LINK_RESET_CYCLES default.
- One sub-module: sync2 (2-flop synchronizer for waiting_bit), reusable for other cross-board inputs.

## Test plan
- Nominal: instr=10'h2CE against behavioural receiver model → receiver word 10'h2CE, ten confirm pulses, one done, error=0.
- Back-to-back: 10'h3FF then 10'h001 → both received exactly, LINK_RST precedes each frame, link_reset high 4 cycles each.
- Timeout: TIMEOUT_CYCLES=64, waiting_bit tied 0 → error=1 after 64 cycles in WAIT_RDY, link_reset 4 cycles, return to IDLE, no done.
- Abort after third bit's HOLD → confirm_bit drops next cycle, link_reset 4 cycles, IDLE, error=0, no done.
- start held high during frame with instr changing → transmitted word is the value captured at acceptance.
- Reset asserted in HOLD of bit 5 → all outputs at reset values next cycle; following start delivers full word correctly.
